// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// master = loader side, slave = stream source / instruction memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to
// instruction memory and holds the CPU in reset until the program is loaded.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.master       bus,
  input  logic                reload,
  output logic                cpu_reset,
  output logic                pc_write,
  output logic                load_done,
  output logic                load_error,
  output logic [31:0]         word_count
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  // Largest program that still fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] CAP = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_t                state_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           shift_q;   // bytes already received of the current word
  logic [31:0]           len_q;
  logic [31:0]           word_count_q;
  logic                  in_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  cpu_reset_q;
  logic                  load_done_q;
  logic                  load_error_q;

  logic                  fire;
  logic                  last_byte;
  logic [31:0]           word_d;

  assign fire      = bus.in_valid & in_ready_q;
  assign last_byte = fire & (byte_idx_q == 2'd3);
  assign word_d    = {shift_q, bus.in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN;
      byte_idx_q   <= 2'd0;
      shift_q      <= '0;
      len_q        <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else if (reload) begin
      // A byte handshaking on this edge is dropped along with any partial word.
      state_q      <= S_LEN;
      byte_idx_q   <= 2'd0;
      shift_q      <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q   <= 1'b0;
      cpu_reset_q <= (state_q != S_DONE);
      if (fire) begin
        shift_q    <= word_d[23:0];
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      case (state_q)
        S_LEN: begin
          if (last_byte) begin
            len_q <= word_d;
            if (word_d == 32'd0) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else if ({1'b0, word_d} > CAP) begin
              state_q      <= S_ERR;
              in_ready_q   <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            imem_we_q    <= 1'b1;
            imem_wdata_q <= word_d;
            imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + word_count_q[ADDR_WIDTH-1:0];
            word_count_q <= word_count_q + 32'd1;
            // Final word: enter DONE on the same edge; cpu_reset drops one edge later.
            if (word_count_q + 32'd1 == len_q) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign pc_write       = ~cpu_reset_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;
  assign word_count     = word_count_q;

endmodule
